// File: rtl/cache_fill_ctrl_pkg.sv
// Shared definitions for the cache miss-fill sequencer: FSM states, block geometry
// and address field helpers.
package cache_fill_ctrl_pkg;

  localparam int ADDR_W        = 16;
  localparam int WORDS_PER_BLK = 8;
  localparam int OFFSET_W      = 4;
  localparam int WORD_IDX_W    = $clog2(WORDS_PER_BLK);

  localparam int TAG_MSB = 15;
  localparam int TAG_LSB = 10;
  localparam int SET_MSB = 9;
  localparam int SET_LSB = 4;
  localparam int TAG_W   = TAG_MSB - TAG_LSB + 1;
  localparam int SET_W   = SET_MSB - SET_LSB + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    TAG_WR = 2'd2
  } fill_state_e;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [SET_W-1:0]    set_idx;
    logic [OFFSET_W-1:0] offset;
  } blk_addr_t;

  function automatic logic [ADDR_W-1:0] blk_base(input logic [ADDR_W-1:0] addr);
    blk_addr_t a;
    a        = addr;
    a.offset = '0;
    return a;
  endfunction

  // Word index replaces the offset field directly, so the address can never carry
  // out of the block.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0]     base,
                                                  input logic [WORD_IDX_W-1:0] idx);
    return {base[ADDR_W-1:OFFSET_W], idx, 1'b0};
  endfunction

endpackage

// File: rtl/cache_fill_ctrl_fill_word_counter.sv
// Word counter for one side of a block fill: counts up to WORDS_PER_BLK steps, then
// holds until cleared, and emits a one-hot select for the word stepped this cycle.
module fill_word_counter
  import cache_fill_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     inc,
  output logic [WORD_IDX_W-1:0]    cnt,
  output logic [WORDS_PER_BLK-1:0] sel
);

  logic [WORD_IDX_W-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  step;

  assign step = inc && !done_q;
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    sel    = '0;
    if (step) begin
      sel[cnt_q] = 1'b1;
    end
    if (clr) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == WORD_IDX_W'(WORDS_PER_BLK - 1)) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss-handling sequencer: issues eight word reads for a missing block, steers the
// returned words into the data array, then strobes the metadata tag write once.
//
// state  | meaning
// IDLE   | waiting for a miss; returns from memory are ignored
// FILL   | issuing reads and writing returned words into the data array
// TAG_WR | one-cycle metadata write after the last word has landed
module cache_fill_ctrl
  import cache_fill_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_detected,
  input  logic [ADDR_W-1:0]        miss_addr,
  input  logic                     memory_data_valid,
  output logic                     fsm_busy,
  output logic                     mem_read_en,
  output logic [ADDR_W-1:0]        memory_address,
  output logic                     write_data_array,
  output logic [ADDR_W-1:0]        data_array_addr,
  output logic [WORDS_PER_BLK-1:0] fill_word_sel,
  output logic                     write_tag_array,
  output logic [ADDR_W-1:0]        fill_addr
);

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;

  logic                     start_fill;
  logic                     issue_inc, recv_inc;
  logic [WORD_IDX_W-1:0]    issue_cnt, recv_cnt;
  logic [WORDS_PER_BLK-1:0] issue_sel, recv_sel;

  assign start_fill = (state_q == IDLE) && miss_detected;
  assign issue_inc  = (state_q == FILL);
  assign recv_inc   = (state_q == FILL) && memory_data_valid;

  fill_word_counter u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_fill),
    .inc (issue_inc),
    .cnt (issue_cnt),
    .sel (issue_sel)
  );

  // Returns arrive in issue order, so a separate receive count is enough to pair
  // each returned word with its offset.
  fill_word_counter u_recv_cnt (
    .clk (clk),
    .rst (rst),
    .clr (start_fill),
    .inc (recv_inc),
    .cnt (recv_cnt),
    .sel (recv_sel)
  );

  always_comb begin
    state_d          = state_q;
    fill_addr_d      = fill_addr_q;
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    data_array_addr  = '0;
    fill_word_sel    = '0;
    write_tag_array  = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          fill_addr_d = blk_base(miss_addr);
          state_d     = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (|issue_sel) begin
          mem_read_en    = 1'b1;
          memory_address = word_addr(fill_addr_q, issue_cnt);
        end
        if (|recv_sel) begin
          write_data_array = 1'b1;
          fill_word_sel    = recv_sel;
          data_array_addr  = word_addr(fill_addr_q, recv_cnt);
          if (recv_cnt == WORD_IDX_W'(WORDS_PER_BLK - 1)) begin
            state_d = TAG_WR;
          end
        end
      end
      TAG_WR: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        state_d         = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fill_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
    end
  end

  assign fill_addr = fill_addr_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl with a fixed-latency memory model that can
// throttle returns and inject spurious valids.
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_addr;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [15:0] data_array_addr;
  logic [7:0]  fill_word_sel;
  logic        write_tag_array;
  logic [15:0] fill_addr;

  int checks = 0;
  int errors = 0;

  logic [15:0] pipe = '0;
  int          pending = 0;
  int          lat = 4;
  bit          gate_alt = 1'b0;
  bit          spur = 1'b0;
  int          mcyc = 0;
  bit          mdl_valid;

  always #5 clk = ~clk;

  cache_fill_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_addr         (miss_addr),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .data_array_addr   (data_array_addr),
    .fill_word_sel     (fill_word_sel),
    .write_tag_array   (write_tag_array),
    .fill_addr         (fill_addr)
  );

  // Memory model: a read issued in cycle k becomes available in cycle k+lat;
  // with gate_alt, at most one word is returned every other cycle.
  always @(posedge clk) begin
    #1;
    if (pipe[lat-1]) pending++;
    if (pending > 0 && (!gate_alt || mcyc[0])) begin
      mdl_valid = 1'b1;
      pending--;
    end else begin
      mdl_valid = 1'b0;
    end
    pipe = {pipe[14:0], mem_read_en};
    mcyc++;
    memory_data_valid = mdl_valid | spur;
  end

  task automatic model_setup(input int l, input bit alt);
    lat      = l;
    gate_alt = alt;
    pending  = 0;
    pipe     = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_addr = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({fsm_busy, mem_read_en, write_data_array, write_tag_array} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got busy/rd/wr/tag=%b want 0000",
               {fsm_busy, mem_read_en, write_data_array, write_tag_array});
    end
    checks++;
    if ({memory_address, data_array_addr, fill_word_sel, fill_addr} !== 56'h0) begin
      errors++;
      $display("FAIL reset_data: got maddr=%h daddr=%h sel=%h fill=%h want all 0",
               memory_address, data_array_addr, fill_word_sel, fill_addr);
    end
    miss_detected = 1'b1;
    miss_addr = 16'h4444;
    @(negedge clk);
    checks++;
    if (fsm_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: got busy=%b want 0", fsm_busy);
    end
    rst = 1'b0;
    miss_detected = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill(input logic [15:0] addr, input int l);
    logic [15:0] base, exp_maddr, exp_daddr;
    logic [7:0]  exp_sel;
    logic        exp_busy, exp_rd, exp_wr, exp_tag;
    int          busy_cnt;
    base = {addr[15:4], 4'h0};
    busy_cnt = 0;
    model_setup(l, 1'b0);
    miss_addr = addr;
    miss_detected = 1'b1;
    for (int c = 1; c <= l + 12; c++) begin
      @(negedge clk);
      miss_detected = 1'b0;
      exp_busy  = (c <= 9 + l);
      exp_rd    = (c <= 8);
      exp_maddr = exp_rd ? base + 16'(2 * (c - 1)) : 16'h0;
      exp_wr    = (c > l) && (c <= 8 + l);
      exp_sel   = exp_wr ? 8'(1 << (c - 1 - l)) : 8'h00;
      exp_daddr = exp_wr ? base + 16'(2 * (c - 1 - l)) : 16'h0;
      exp_tag   = (c == 9 + l);
      if (fsm_busy) busy_cnt++;
      checks++;
      if ({fsm_busy, mem_read_en, memory_address} !== {exp_busy, exp_rd, exp_maddr}) begin
        errors++;
        $display("FAIL fill_issue c=%0d: got busy=%b rd=%b addr=%h want busy=%b rd=%b addr=%h",
                 c, fsm_busy, mem_read_en, memory_address, exp_busy, exp_rd, exp_maddr);
      end
      checks++;
      if ({write_data_array, fill_word_sel, data_array_addr} !== {exp_wr, exp_sel, exp_daddr}) begin
        errors++;
        $display("FAIL fill_write c=%0d: got wr=%b sel=%h addr=%h want wr=%b sel=%h addr=%h",
                 c, write_data_array, fill_word_sel, data_array_addr, exp_wr, exp_sel, exp_daddr);
      end
      checks++;
      if (write_tag_array !== exp_tag) begin
        errors++;
        $display("FAIL fill_tag c=%0d: got %b want %b", c, write_tag_array, exp_tag);
      end
      if (exp_busy) begin
        checks++;
        if (fill_addr !== base) begin
          errors++;
          $display("FAIL fill_addr c=%0d: got %h want %h", c, fill_addr, base);
        end
      end
    end
    checks++;
    if (busy_cnt != 9 + l) begin
      errors++;
      $display("FAIL fill_busy_len: got %0d cycles want %0d", busy_cnt, 9 + l);
    end
  endtask

  task automatic test_stall;
    logic [15:0] base;
    int wr_cnt, tag_cnt, last_wr, rd_cnt;
    base = 16'h2460;
    wr_cnt = 0;
    tag_cnt = 0;
    last_wr = -10;
    rd_cnt = 0;
    model_setup(2, 1'b1);
    miss_addr = 16'h246B;
    miss_detected = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      miss_detected = 1'b0;
      if (mem_read_en) begin
        checks++;
        if (c > 8 || memory_address !== base + 16'(2 * rd_cnt)) begin
          errors++;
          $display("FAIL stall_read c=%0d: got addr=%h want %h within cycles 1..8",
                   c, memory_address, base + 16'(2 * rd_cnt));
        end
        rd_cnt++;
      end
      if (write_data_array) begin
        checks++;
        if (fill_word_sel !== 8'(1 << wr_cnt) || data_array_addr !== base + 16'(2 * wr_cnt)) begin
          errors++;
          $display("FAIL stall_write #%0d: got sel=%h addr=%h want sel=%h addr=%h",
                   wr_cnt, fill_word_sel, data_array_addr, 8'(1 << wr_cnt), base + 16'(2 * wr_cnt));
        end
        wr_cnt++;
        last_wr = c;
      end
      if (write_tag_array) begin
        checks++;
        if (wr_cnt != 8 || last_wr != c - 1) begin
          errors++;
          $display("FAIL stall_tag_order: got %0d words, last write c=%0d, tag c=%0d want 8 words ending c-1",
                   wr_cnt, last_wr, c);
        end
        tag_cnt++;
      end
    end
    checks++;
    if (wr_cnt != 8 || tag_cnt != 1 || rd_cnt != 8) begin
      errors++;
      $display("FAIL stall_totals: got writes=%0d tags=%0d reads=%0d want 8/1/8", wr_cnt, tag_cnt, rd_cnt);
    end
  endtask

  task automatic test_miss_held;
    model_setup(2, 1'b0);
    miss_addr = 16'h0AB6;
    miss_detected = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      if (c == 14) miss_detected = 1'b0;
      checks++;
      if (write_tag_array && mem_read_en) begin
        errors++;
        $display("FAIL held_overlap c=%0d: got tag and read together want exclusive", c);
      end
      if (c == 11 || c == 23) begin
        checks++;
        if (write_tag_array !== 1'b1) begin
          errors++;
          $display("FAIL held_tag c=%0d: got %b want 1", c, write_tag_array);
        end
      end
      if (c == 12 || c == 24) begin
        checks++;
        if ({fsm_busy, mem_read_en, write_data_array} !== 3'b000) begin
          errors++;
          $display("FAIL held_idle c=%0d: got busy/rd/wr=%b want 000", c,
                   {fsm_busy, mem_read_en, write_data_array});
        end
      end
      if (c == 13) begin
        checks++;
        if ({fsm_busy, mem_read_en, memory_address} !== {2'b11, 16'h0AB0}) begin
          errors++;
          $display("FAIL held_restart: got busy=%b rd=%b addr=%h want 1 1 0ab0",
                   fsm_busy, mem_read_en, memory_address);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    model_setup(4, 1'b0);
    miss_addr = 16'h5A5C;
    miss_detected = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      miss_detected = 1'b0;
      if (c == 7) begin
        checks++;
        if ({write_data_array, fill_word_sel, data_array_addr} !== {1'b1, 8'h04, 16'h5A54}) begin
          errors++;
          $display("FAIL rstmid_third: got wr=%b sel=%h addr=%h want 1 04 5a54",
                   write_data_array, fill_word_sel, data_array_addr);
        end
        rst = 1'b1;
      end
      if (c == 8) begin
        checks++;
        if ({fsm_busy, mem_read_en, write_data_array, write_tag_array, fill_word_sel,
             memory_address, data_array_addr, fill_addr} !== 60'h0) begin
          errors++;
          $display("FAIL rstmid_idle: got busy=%b rd=%b wr=%b tag=%b sel=%h fill=%h want all 0",
                   fsm_busy, mem_read_en, write_data_array, write_tag_array, fill_word_sel, fill_addr);
        end
        rst = 1'b0;
      end
      if (c >= 8) begin
        checks++;
        if ({fsm_busy, write_data_array, write_tag_array} !== 3'b000) begin
          errors++;
          $display("FAIL rstmid_after c=%0d: got busy/wr/tag=%b want 000", c,
                   {fsm_busy, write_data_array, write_tag_array});
        end
      end
    end
  endtask

  task automatic test_spurious;
    model_setup(2, 1'b0);
    miss_addr = 16'h8000;
    miss_detected = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      miss_detected = 1'b0;
      if (c == 10) spur = 1'b1;
      if (c == 14) spur = 1'b0;
      if (c == 11) begin
        checks++;
        if ({write_tag_array, write_data_array, fill_word_sel} !== {2'b10, 8'h00}) begin
          errors++;
          $display("FAIL spur_tagwr: got tag=%b wr=%b sel=%h want 1 0 00",
                   write_tag_array, write_data_array, fill_word_sel);
        end
      end
      if (c >= 12 && c <= 14) begin
        checks++;
        if ({fsm_busy, write_data_array, data_array_addr} !== 18'h0) begin
          errors++;
          $display("FAIL spur_idle c=%0d: got busy=%b wr=%b addr=%h want 0 0 0000",
                   c, fsm_busy, write_data_array, data_array_addr);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_addr = 16'h0000;
    test_reset();
    test_fill(16'h1234, 4);
    test_stall();
    test_miss_held();
    test_reset_mid();
    test_spurious();
    test_fill(16'hFFFF, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
